// File: rtl/key_debouncer_if.sv
// key_debouncer_if: raw key pin in, debounced level and event pulses out.
// master drives the pin and consumes events; slave is the debouncer.
interface key_debouncer_if;
  logic iKey;
  logic oKey;
  logic oPress;
  logic oRelease;
  logic oLongPress;

  modport master (
    output iKey,
    input  oKey,
    input  oPress,
    input  oRelease,
    input  oLongPress
  );

  modport slave (
    input  iKey,
    output oKey,
    output oPress,
    output oRelease,
    output oLongPress
  );
endinterface

// File: rtl/key_debouncer.sv
// key_debouncer: synchronizes and filters an active-low key pin.
// Define KEY_DEBOUNCER_REPEAT_EN for auto-repeat while long-pressed.
module key_debouncer #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int LONG_CYCLES     = 1000,
  parameter int REPEAT_CYCLES   = 200,
  parameter int CNT_WIDTH       = 10
) (
  input logic            iClock,
  input logic            iReset,
  key_debouncer_if.slave kif
);

  localparam int CMAX = (1 << CNT_WIDTH) - 1;

  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > CMAX ||
      LONG_CYCLES <= DEBOUNCE_CYCLES || LONG_CYCLES > CMAX ||
      REPEAT_CYCLES < 1 || REPEAT_CYCLES > CMAX) begin : g_bad_params
    $error("key_debouncer: illegal parameter set");
  end

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
  localparam logic [CNT_WIDTH-1:0] DB_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LONG_C  = CNT_WIDTH'(LONG_CYCLES);
  localparam bit                   DB_ONE  = (DEBOUNCE_CYCLES == 1);
`ifdef KEY_DEBOUNCER_REPEAT_EN
  localparam logic [CNT_WIDTH-1:0] REP_C   = CNT_WIDTH'(REPEAT_CYCLES);
`endif

  typedef enum logic [2:0] {
    IDLE, PRESS_WAIT, HELD, LONG, REL_WAIT
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_WIDTH-1:0] dbnc_q, dbnc_d;
  logic [CNT_WIDTH-1:0] hold_q, hold_d;
  logic [CNT_WIDTH-1:0] hold_inc;
  logic                 long_q, long_d;
  logic                 press_q, press_d;
  logic                 rel_q, rel_d;
  logic                 lp_q, lp_d;
  logic                 sync1_q, sync2_q;
  logic                 sync_key;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= kif.iKey;
      sync2_q <= sync1_q;
    end
  end

  assign sync_key = sync2_q;
  assign hold_inc = (hold_q == CNT_MAX) ? hold_q : hold_q + CNT_ONE;

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q <= IDLE;
      dbnc_q  <= '0;
      hold_q  <= '0;
      long_q  <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      lp_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      dbnc_q  <= dbnc_d;
      hold_q  <= hold_d;
      long_q  <= long_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      lp_q    <= lp_d;
    end
  end

  always_comb begin
    state_d = state_q;
    dbnc_d  = dbnc_q;
    hold_d  = hold_q;
    long_d  = long_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    lp_d    = 1'b0;
    unique case (state_q)
      IDLE: begin
        dbnc_d = '0;
        hold_d = '0;
        long_d = 1'b0;
        if (!sync_key) begin
          if (DB_ONE) begin
            state_d = HELD;
            press_d = 1'b1;
          end else begin
            state_d = PRESS_WAIT;
            dbnc_d  = CNT_ONE;
          end
        end
      end
      PRESS_WAIT: begin
        if (sync_key) begin
          state_d = IDLE;
          dbnc_d  = '0;
        end else if (dbnc_q == DB_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          dbnc_d  = '0;
          hold_d  = '0;
        end else begin
          dbnc_d = dbnc_q + CNT_ONE;
        end
      end
      HELD, LONG: begin
        if (sync_key) begin
          long_d = (state_q == LONG);
          if (DB_ONE) begin
            state_d = IDLE;
            rel_d   = 1'b1;
            dbnc_d  = '0;
            hold_d  = '0;
          end else begin
            state_d = REL_WAIT;
            dbnc_d  = CNT_ONE;
          end
        end else if (state_q == HELD) begin
          hold_d = hold_inc;
          if (hold_inc == LONG_C) begin
            state_d = LONG;
            lp_d    = 1'b1;
`ifdef KEY_DEBOUNCER_REPEAT_EN
            hold_d  = '0;
`endif
          end
        end else begin
`ifdef KEY_DEBOUNCER_REPEAT_EN
          // hold counter doubles as the repeat phase once long-pressed
          if (hold_inc == REP_C) begin
            press_d = 1'b1;
            hold_d  = '0;
          end else begin
            hold_d = hold_inc;
          end
`else
          hold_d = hold_inc;
`endif
        end
      end
      REL_WAIT: begin
        if (!sync_key) begin
          state_d = long_q ? LONG : HELD;
          dbnc_d  = '0;
        end else if (dbnc_q == DB_LAST) begin
          state_d = IDLE;
          rel_d   = 1'b1;
          dbnc_d  = '0;
          hold_d  = '0;
        end else begin
          dbnc_d = dbnc_q + CNT_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    kif.oKey       = (state_q == HELD) || (state_q == LONG) ||
                     (state_q == REL_WAIT);
    kif.oPress     = press_q;
    kif.oRelease   = rel_q;
    kif.oLongPress = lp_q;
  end

endmodule

// File: tb/tb_key_debouncer.sv
// tb_key_debouncer: scenario tasks plus randomized stream, all checked
// against a run-length model of the debounce and hold rules.
module tb_key_debouncer;

  localparam int D = 4;
  localparam int L = 20;
  localparam int R = 8;
  localparam int W = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;

  key_debouncer_if kif ();

  key_debouncer #(
    .DEBOUNCE_CYCLES(D),
    .LONG_CYCLES    (L),
    .REPEAT_CYCLES  (R),
    .CNT_WIDTH      (W)
  ) dut (
    .iClock(clk),
    .iReset(rst),
    .kif   (kif)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] obs;
  assign obs = {kif.oKey, kif.oPress, kif.oRelease, kif.oLongPress};

  // model: {key, press, release, long} expected after each edge
  logic [3:0] m_exp  = '0;
  logic       m_s1   = 1'b1;
  logic       m_s2   = 1'b1;
  logic       m_pr   = 1'b0;
  bit         m_long = 1'b0;
  int         m_run  = 0;
  int         m_hold = 0;

  function automatic void model(input logic k, input logic r);
    logic s;
    m_exp = '0;
    if (r) begin
      m_s1 = 1'b1; m_s2 = 1'b1; m_pr = 1'b0;
      m_run = 0; m_hold = 0; m_long = 1'b0;
      return;
    end
    s = m_s2;
    m_s2 = m_s1;
    m_s1 = k;
    if (!m_pr) begin
      m_run = s ? 0 : m_run + 1;
      if (m_run == D) begin
        m_pr = 1'b1; m_run = 0; m_hold = 0; m_long = 1'b0;
        m_exp[2] = 1'b1;
      end
    end else if (s) begin
      m_run++;
      if (m_run == D) begin
        m_pr = 1'b0; m_run = 0;
        m_exp[1] = 1'b1;
      end
    end else begin
      // held time only advances while no release bounce is pending
      if (m_run == 0) begin
        m_hold++;
        if (m_hold == L && !m_long) begin
          m_long = 1'b1;
          m_exp[0] = 1'b1;
        end
`ifdef KEY_DEBOUNCER_REPEAT_EN
        else if (m_long && m_hold > L && (m_hold - L) % R == 0) begin
          m_exp[2] = 1'b1;
        end
`endif
      end
      m_run = 0;
    end
    m_exp[3] = m_pr;
  endfunction

  task automatic cyc(input logic k, input logic r);
    kif.iKey = k;
    rst = r;
    @(posedge clk);
    model(k, r);
    @(negedge clk);
  endtask

  task automatic test_reset();
    cyc(1'b0, 1'b1);
    cyc(1'b0, 1'b1);
    n_tests++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_out: got %b want 0000", obs);
    end
    n_tests++;
    if ({dut.sync1_q, dut.sync2_q} !== 2'b11) begin
      n_fail++;
      $display("FAIL reset_sync: got %b want 11", {dut.sync1_q, dut.sync2_q});
    end
    n_tests++;
    if (dut.dbnc_q !== '0 || dut.hold_q !== '0) begin
      n_fail++;
      $display("FAIL reset_cnt: got %0d/%0d want 0/0", dut.dbnc_q, dut.hold_q);
    end
    for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_glitch();
    int nev = 0;
    for (int i = 0; i < 15; i++) begin
      cyc((i < 3) ? 1'b0 : 1'b1, 1'b0);
      if (obs !== 4'b0000) nev++;
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL glitch c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (nev !== 0) begin
      n_fail++;
      $display("FAIL glitch_events: got %0d want 0", nev);
    end
  endtask

  task automatic test_press_release();
    int p_at = -1;
    int np = 0;
    int r_at = -1;
    int nr = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b0, 1'b0);
      if (obs[2]) begin np++; if (p_at < 0) p_at = i; end
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL press c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (p_at != D + 2 || np != 1) begin
      n_fail++;
      $display("FAIL press_lat: got edge %0d x%0d want edge %0d x1", p_at, np, D + 2);
    end
    for (int i = 1; i <= 12; i++) begin
      cyc(1'b1, 1'b0);
      if (obs[1]) begin nr++; if (r_at < 0) r_at = i; end
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL release c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (r_at != D + 2 || nr != 1 || obs[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL release_lat: got edge %0d x%0d key %b want edge %0d x1 key 0",
               r_at, nr, obs[3], D + 2);
    end
  endtask

  task automatic test_long_clean();
    int p_at = -1;
    int l_at = -1;
    int nl = 0;
    for (int i = 1; i <= 40; i++) begin
      cyc(1'b0, 1'b0);
      if (obs[2] && p_at < 0) p_at = i;
      if (obs[0]) begin nl++; if (l_at < 0) l_at = i; end
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL long c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (nl != 1 || l_at - p_at != L) begin
      n_fail++;
      $display("FAIL long_lat: got +%0d x%0d want +%0d x1", l_at - p_at, nl, L);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_long_glitch();
    int nl = 0;
    int drops = 0;
    logic k;
    for (int i = 1; i <= 60; i++) begin
      k = (i >= D + 12 && i < D + 14) ? 1'b1 : 1'b0;
      cyc(k, 1'b0);
      if (obs[0]) nl++;
      if (i > D + 2 && obs[3] !== 1'b1) drops++;
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL lglitch c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (nl != 1 || drops != 0) begin
      n_fail++;
      $display("FAIL lglitch_sum: got long x%0d drops %0d want x1 drops 0", nl, drops);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_repeat();
    int pq[$];
    for (int i = 1; i <= 70; i++) begin
      cyc(1'b0, 1'b0);
      if (obs[2]) pq.push_back(i);
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL repeat c%0d: got %b want %b", i, obs, m_exp);
      end
    end
`ifdef KEY_DEBOUNCER_REPEAT_EN
    n_tests++;
    if (pq.size() < 4 || pq[0] != D + 2 || pq[1] - pq[0] != L + R ||
        pq[2] - pq[0] != L + 2 * R || pq[3] - pq[0] != L + 3 * R) begin
      n_fail++;
      $display("FAIL repeat_times: got %0d presses want at +0,+%0d,+%0d,+%0d",
               pq.size(), L + R, L + 2 * R, L + 3 * R);
    end
`else
    n_tests++;
    if (pq.size() != 1) begin
      n_fail++;
      $display("FAIL single_press: got %0d presses want 1", pq.size());
    end
`endif
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_reset_mid_press();
    int p_at = -1;
    int nr = 0;
    for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0);
    cyc(1'b0, 1'b1);
    n_tests++;
    if (obs !== 4'b0000) begin
      n_fail++;
      $display("FAIL midrst_out: got %b want 0000", obs);
    end
    for (int i = 1; i <= 10; i++) begin
      cyc(1'b0, 1'b0);
      if (obs[2] && p_at < 0) p_at = i;
      if (obs[1]) nr++;
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL midrst c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (p_at != D + 2 || nr != 0) begin
      n_fail++;
      $display("FAIL midrst_press: got edge %0d rel x%0d want edge %0d rel x0",
               p_at, nr, D + 2);
    end
    for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
  endtask

  task automatic test_release_bounce();
    int nr = 0;
    int drops = 0;
    for (int i = 0; i < 10; i++) cyc(1'b0, 1'b0);
    for (int i = 0; i < 35; i++) begin
      cyc((i >= 20 || (i / 2) % 2 == 0) ? 1'b1 : 1'b0, 1'b0);
      if (i < 20 && obs[3] !== 1'b1) drops++;
      if (obs[1]) nr++;
      n_tests++;
      if (obs !== m_exp) begin
        n_fail++;
        $display("FAIL rbounce c%0d: got %b want %b", i, obs, m_exp);
      end
    end
    n_tests++;
    if (nr != 1 || drops != 0 || obs[3] !== 1'b0) begin
      n_fail++;
      $display("FAIL rbounce_sum: got rel x%0d drops %0d key %b want x1 0 0",
               nr, drops, obs[3]);
    end
  endtask

  task automatic test_random();
    logic k = 1'b1;
    int len;
    int cnt = 0;
    while (cnt < 3000) begin
      k = ~k;
      len = $urandom_range(1, ($urandom_range(0, 3) == 0) ? 45 : 7);
      for (int j = 0; j < len; j++) begin
        cyc(k, ($urandom_range(0, 499) == 0) ? 1'b1 : 1'b0);
        cnt++;
        n_tests++;
        if (obs !== m_exp) begin
          n_fail++;
          $display("FAIL random c%0d: got %b want %b", cnt, obs, m_exp);
        end
      end
    end
  endtask

  initial begin
    kif.iKey = 1'b1;
    @(negedge clk);
    test_reset();
    test_glitch();
    test_press_release();
    test_long_clean();
    test_long_glitch();
    test_repeat();
    test_reset_mid_press();
    test_release_bounce();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
